capture_controller: RTL

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

---
 rtl/capture_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/capture_controller.sv
`default_nettype none
// ============================================================================
// Module      : capture_controller
// Description : Logic-analyser capture sequencer. Synchronizes the probe
//               inputs, samples them at a programmable rate, detects a
//               rising or falling edge on a selected channel, and drives the
//               shift strobe for the downstream capture registers until
//               POST_SAMPLES post-trigger samples have been taken.
//               Optional feature macro: CAPTURE_AUTO_REARM_EN (DONE returns
//               to ARMED after HOLD_CYCLES cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module capture_controller #(
    parameter int CHANNEL_COUNT = 10,
    parameter int POST_SAMPLES  = 320,
    parameter int HOLD_CYCLES   = 50_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNEL_COUNT-1:0]         chan_in,
    input  logic                             arm,
    input  logic [$clog2(CHANNEL_COUNT)-1:0] trig_chan,
    input  logic                             trig_falling,
    input  logic [31:0]                      rate_div,
    output logic [CHANNEL_COUNT-1:0]         sample_out,
    output logic                             shift,
    output logic                             triggered,
    output logic                             frozen,
    output logic [1:0]                       state
);

    localparam int TW = $clog2(CHANNEL_COUNT);
    localparam int PW = $clog2(POST_SAMPLES + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARMED   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [CHANNEL_COUNT-1:0] r_sync1;
    logic [CHANNEL_COUNT-1:0] r_sync2;
    logic [CHANNEL_COUNT-1:0] r_prev;
    logic [31:0]              r_div_cnt;
    logic                     w_tick;
    logic                     r_tick_d;
    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic                     r_hist_valid;
    logic [PW-1:0]            r_post_cnt;
    logic                     w_post_last;
    logic                     w_new_bit;
    logic                     w_old_bit;
    logic                     w_chan_valid;
    logic                     w_edge;
    logic                     w_hold_done;

    assign state = r_state;

    // Two-flop synchronizer on every probe channel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= chan_in;
            r_sync2 <= r_sync1;
        end
    end

    // Sample-rate divider; a count above a newly lowered rate_div wraps through max
    assign w_tick = (r_div_cnt == rate_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_tick_d  <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? 32'd0 : r_div_cnt + 32'd1;
            r_tick_d  <= w_tick;
        end
    end

    // Sample register plus one-deep history for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out <= '0;
            r_prev     <= '0;
        end else if (w_tick) begin
            sample_out <= r_sync2;
            r_prev     <= sample_out;
        end
    end

    // Select the trigger channel's new and previous bits; out-of-range selects nothing
    always_comb begin
        w_new_bit = 1'b0;
        w_old_bit = 1'b0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (trig_chan == TW'(i)) begin
                w_new_bit = sample_out[i];
                w_old_bit = r_prev[i];
            end
        end
    end

    assign w_chan_valid = (int'(trig_chan) < CHANNEL_COUNT);
    assign w_edge       = trig_falling ? (w_old_bit & ~w_new_bit) : (~w_old_bit & w_new_bit);
    assign w_post_last  = (r_post_cnt == PW'(POST_SAMPLES - 1));

    // History becomes trustworthy only after one shift has been taken in ARMED
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist_valid <= 1'b0;
        end else if (r_state != c_ARMED) begin
            r_hist_valid <= 1'b0;
        end else if (shift) begin
            r_hist_valid <= 1'b1;
        end
    end

    // Post-trigger shift counter, cleared on entry to CAPTURE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_post_cnt <= '0;
        end else if (r_state != c_CAPTURE) begin
            r_post_cnt <= '0;
        end else if (shift) begin
            r_post_cnt <= r_post_cnt + PW'(1);
        end
    end

`ifdef CAPTURE_AUTO_REARM_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    logic [HW-1:0] r_hold_cnt;

    // Dwell timer for DONE; idle at zero in every other state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else if (r_state != c_DONE) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
        end
    end

    assign w_hold_done = (r_state == c_DONE) && (r_hold_cnt == HW'(HOLD_CYCLES - 1));
`else
    assign w_hold_done = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (arm) w_next_state = c_ARMED;
            c_ARMED:   if (triggered) w_next_state = c_CAPTURE;
            c_CAPTURE: if (shift && w_post_last) w_next_state = c_DONE;
            c_DONE:    if (arm || w_hold_done) w_next_state = c_ARMED;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // FSM outputs; shift follows the tick by one cycle so sample_out is already loaded
    always_comb begin
        shift     = r_tick_d && ((r_state == c_ARMED) || (r_state == c_CAPTURE));
        triggered = shift && (r_state == c_ARMED) && r_hist_valid && w_chan_valid && w_edge;
        frozen    = (r_state == c_DONE) || (r_state == c_IDLE);
    end

endmodule
`default_nettype wire
